// File: rtl/dmem_responder_pkg.sv
// ---------------------------------------------------------------------------
// dmem_responder_pkg
// Shared definitions for the data-memory responder:
//   XLEN          - data and address width
//   DMEM_DEPTH    - default number of 32-bit words
//   dmem_state_e  - FSM state encodings (DMEM_ST_CLEAR, DMEM_ST_SERVE)
// ---------------------------------------------------------------------------
package dmem_responder_pkg;

    localparam int XLEN       = 32;
    localparam int DMEM_DEPTH = 256;

    typedef enum logic {
        DMEM_ST_CLEAR = 1'b0,
        DMEM_ST_SERVE = 1'b1
    } dmem_state_e;

endpackage

// File: rtl/dmem_array.sv
// ---------------------------------------------------------------------------
// dmem_array
// Word storage for dmem_responder: one synchronous write port and one
// asynchronous (combinational) read port. Contents are not reset; the
// responder zeroes every word after reset.
// Ports:
//   clk      - clock
//   we_i     - write enable
//   waddr_i  - write word index
//   wdata_i  - write data
//   raddr_i  - read word index
//   rdata_o  - read data (combinational)
// ---------------------------------------------------------------------------
module dmem_array
    import dmem_responder_pkg::*;
#(
    parameter  int DEPTH = DMEM_DEPTH,
    localparam int AW    = $clog2(DEPTH)
) (
    input  logic            clk,
    input  logic            we_i,
    input  logic [AW-1:0]   waddr_i,
    input  logic [XLEN-1:0] wdata_i,
    input  logic [AW-1:0]   raddr_i,
    output logic [XLEN-1:0] rdata_o
);

    logic [XLEN-1:0] mem_q [DEPTH];

    always_ff @(posedge clk) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    // Read sees the pre-edge contents, so a same-cycle read of a word being
    // written returns the old value.
    assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/dmem_responder.sv
// ---------------------------------------------------------------------------
// dmem_responder
// Single-cycle data memory for a core data port. After reset the whole
// array is zeroed one word per cycle (CLEAR); afterwards accesses are
// serviced with zero read latency (SERVE).
//
// Optional feature macro: DMEM_STATS_EN enables saturating counters of
// accepted reads/writes; without it the counter ports read 0.
//
// Handshake: ce_i is a single-cycle request qualifier. ready_o is a level,
// not a per-request acknowledge: while ready_o = 1 every cycle with
// ce_i = 1 is either serviced in that cycle or rejected (err_o the next
// cycle); while ready_o = 0 requests are dropped silently. There is no
// stall, so the requester must hold off until ready_o is seen high.
//
// Ports:
//   clk, rst           - clock, synchronous active-high reset
//   ce_i, we_i         - access enable, 1 = write / 0 = read
//   addr_i, data_i     - byte address, write data
//   data_o             - read data, combinational, 0 unless a valid read
//   ready_o            - initialisation complete
//   err_o              - one-cycle pulse for a rejected access
//   rd_count_o         - accepted reads  (DMEM_STATS_EN)
//   wr_count_o         - accepted writes (DMEM_STATS_EN)
//   dbg_state_o        - current FSM state, for observation only
// ---------------------------------------------------------------------------
module dmem_responder
    import dmem_responder_pkg::*;
#(
    parameter int              DEPTH     = DMEM_DEPTH,
    parameter logic [XLEN-1:0] BASE_ADDR = '0
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            ce_i,
    input  logic            we_i,
    input  logic [XLEN-1:0] addr_i,
    input  logic [XLEN-1:0] data_i,
    output logic [XLEN-1:0] data_o,
    output logic            ready_o,
    output logic            err_o,
    output logic [XLEN-1:0] rd_count_o,
    output logic [XLEN-1:0] wr_count_o,
    output dmem_state_e     dbg_state_o
);

    localparam int            AW       = $clog2(DEPTH);
    localparam logic [XLEN:0] SPAN     = (XLEN+1)'(4 * DEPTH);
    localparam logic [AW-1:0] LAST_IDX = AW'(DEPTH - 1);

    dmem_state_e     state_q, state_d;
    logic [AW-1:0]   idx_q, idx_d;
    logic            err_q, err_d;

    logic [XLEN-1:0] offset;
    logic            in_range;
    logic            aligned;
    logic            serving;
    logic            access;
    logic            valid;
    logic [AW-1:0]   word_idx;

    logic            arr_we;
    logic [AW-1:0]   arr_waddr;
    logic [XLEN-1:0] arr_wdata;
    logic [XLEN-1:0] arr_rdata;

    // Range check is done on the offset from BASE_ADDR with one extra bit,
    // so a window touching the top of the address space cannot wrap.
    assign offset   = addr_i - BASE_ADDR;
    assign in_range = ({1'b0, offset} < SPAN);
    assign aligned  = (addr_i[1:0] == 2'b00);
    assign serving  = (state_q == DMEM_ST_SERVE);
    assign access   = ce_i && serving;
    assign valid    = access && aligned && in_range;
    assign word_idx = offset[AW+1:2];

    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        err_d     = access && !(aligned && in_range);
        arr_we    = 1'b0;
        arr_waddr = word_idx;
        arr_wdata = data_i;
        case (state_q)
            DMEM_ST_CLEAR: begin
                // Requests are ignored here; the write port is owned by
                // the clearing sweep.
                arr_we    = 1'b1;
                arr_waddr = idx_q;
                arr_wdata = '0;
                idx_d     = idx_q + 1'b1;
                if (idx_q == LAST_IDX) begin
                    state_d = DMEM_ST_SERVE;
                end
            end
            DMEM_ST_SERVE: begin
                arr_we = valid && we_i;
            end
            default: begin
                state_d = DMEM_ST_CLEAR;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= DMEM_ST_CLEAR;
            idx_q   <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            err_q   <= err_d;
        end
    end

    dmem_array #(
        .DEPTH (DEPTH)
    ) u_array (
        .clk     (clk),
        .we_i    (arr_we),
        .waddr_i (arr_waddr),
        .wdata_i (arr_wdata),
        .raddr_i (word_idx),
        .rdata_o (arr_rdata)
    );

    assign data_o      = (valid && !we_i) ? arr_rdata : '0;
    assign ready_o     = serving;
    assign err_o       = err_q;
    assign dbg_state_o = state_q;

`ifdef DMEM_STATS_EN
    logic [XLEN-1:0] rd_cnt_q, rd_cnt_d;
    logic [XLEN-1:0] wr_cnt_q, wr_cnt_d;

    always_comb begin
        rd_cnt_d = rd_cnt_q;
        wr_cnt_d = wr_cnt_q;
        // Saturate at all-ones rather than wrapping.
        if (valid && !we_i && (rd_cnt_q != '1)) begin
            rd_cnt_d = rd_cnt_q + 1'b1;
        end
        if (valid && we_i && (wr_cnt_q != '1)) begin
            wr_cnt_d = wr_cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rd_cnt_q <= '0;
            wr_cnt_q <= '0;
        end else begin
            rd_cnt_q <= rd_cnt_d;
            wr_cnt_q <= wr_cnt_d;
        end
    end

    assign rd_count_o = rd_cnt_q;
    assign wr_count_o = wr_cnt_q;
`else
    assign rd_count_o = '0;
    assign wr_count_o = '0;
`endif

endmodule
